// File: rtl/vram_snoop.sv
// Screen-memory front end: snoops CPU writes to the screen banks into a small FIFO
// and drains it into single-port VRAM, giving the video reader one slot per pixel period.
module vram_snoop #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          ce_7mn,
  input  logic [15:0]                   addr,
  input  logic [7:0]                    din,
  input  logic                          nMREQ,
  input  logic                          nWR,
  input  logic                          nRFSH,
  input  logic                          m128,
  input  logic [2:0]                    page_ram,
  input  logic [14:0]                   vram_addr,
  output logic [7:0]                    vram_dout,
  output logic [14:0]                   ram_addr,
  output logic [7:0]                    ram_din,
  output logic                          ram_we,
  input  logic [7:0]                    ram_dout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic          wr_act, hit, bank7, cap;
  logic          wr_d, wr_q;
  logic          push_d, push_q;
  logic [14:0]   push_addr_d, push_addr_q;
  logic [7:0]    push_data_d, push_data_q;
  logic          vslot_d, vslot_q;
  logic          rd_pend_d, rd_pend_q;
  logic [7:0]    vram_dout_d, vram_dout_q;
  logic [PW-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic [LW-1:0] level_d, level_q;
  logic          overflow_d, overflow_q;
  logic [22:0]   mem_q [FIFO_DEPTH];
  logic          full, pop, push_ok;

  assign wr_act = ~nMREQ & ~nWR & nRFSH;

  always_comb begin
    hit   = 1'b0;
    bank7 = 1'b0;
    case (addr[15:14])
      2'b01: hit = 1'b1;
      2'b11: begin
        if (m128 && page_ram == 3'd5) hit = 1'b1;
        if (m128 && page_ram == 3'd7) begin
          hit   = 1'b1;
          bank7 = 1'b1;
        end
      end
      default: hit = 1'b0;
    endcase
  end

  assign cap = wr_act & ~wr_q & hit;

  // A V slot preempts draining; a pop in the same cycle frees room for a push into a full FIFO.
  assign full    = (level_q == FULL_LVL);
  assign pop     = ~reset & ~vslot_q & (level_q != '0);
  assign push_ok = push_q & (~full | pop);

  always_comb begin
    wr_d        = wr_act;
    push_d      = cap;
    push_addr_d = {bank7, addr[13:0]};
    push_data_d = din;
    vslot_d     = ce_7mn;
    rd_pend_d   = vslot_q;
    vram_dout_d = rd_pend_q ? ram_dout : vram_dout_q;
    wptr_d      = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d      = pop ? rptr_q + PW'(1) : rptr_q;
    level_d     = level_q;
    if (push_ok && !pop) level_d = level_q + LW'(1);
    if (!push_ok && pop) level_d = level_q - LW'(1);
    overflow_d  = overflow_q | (push_q & ~push_ok);
  end

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (!reset) begin
      if (pop) begin
        ram_addr = mem_q[rptr_q][22:8];
        ram_din  = mem_q[rptr_q][7:0];
        ram_we   = 1'b1;
      end else begin
        ram_addr = vram_addr;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q        <= 1'b1;
      push_q      <= 1'b0;
      push_addr_q <= '0;
      push_data_q <= '0;
      vslot_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      vram_dout_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      push_q      <= push_d;
      push_addr_q <= push_addr_d;
      push_data_q <= push_data_d;
      vslot_q     <= vslot_d;
      rd_pend_q   <= rd_pend_d;
      vram_dout_q <= vram_dout_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset && push_ok) mem_q[wptr_q] <= {push_addr_q, push_data_q};
  end

  assign vram_dout  = vram_dout_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
endmodule

// File: doc/vram_snoop.md
# vram_snoop

Screen-memory front end between the CPU bus and the video controller. Snoops CPU writes to the screen banks (RAM bank 5, and bank 7 in 128K mode) and queues them in a 4-entry write FIFO. Drains the FIFO into a single-port 32 KB VRAM. Serves the video controller's `vram_addr`/`vram_dout` read port with a guaranteed read slot every pixel-clock period.

## Interface

Parameters:
- FIFO_DEPTH, 4, write FIFO entries; power of two; `fifo_level` width is clog2(FIFO_DEPTH)+1.

Ports:
- clk_sys  in  1  master clock
- reset  in  1  synchronous, active-high
- ce_7mn  in  1  pixel-clock enable, negative phase; the video controller updates `vram_addr` on the same edge
- addr  in  16  CPU address bus
- din  in  8  CPU data out (write data)
- nMREQ  in  1  CPU memory request, active low
- nWR  in  1  CPU write strobe, active low
- nRFSH  in  1  CPU refresh, active low
- m128  in  1  128K paging enabled
- page_ram  in  3  RAM bank mapped at 0xC000
- vram_addr  in  15  video read address; bit 14 selects bank 7
- vram_dout  out  8  registered video read data
- ram_addr  out  15  VRAM address
- ram_din  out  8  VRAM write data
- ram_we  out  1  VRAM write enable
- ram_dout  in  8  VRAM read data, 1-cycle registered-read latency
- fifo_level  out  3  current FIFO occupancy, 0..4
- overflow  out  1  sticky; set when a write is dropped

## Operation

Write capture:
- `wr_act = ~nMREQ & ~nWR & nRFSH` is registered each clk_sys into `wr_q`.
- A capture occurs on the rising edge (`wr_act & ~wr_q`), once per CPU write cycle. `addr` and `din` are sampled in that cycle.
- Address decode:
  - addr[15:14]=01: bank 5, entry address {0, addr[13:0]}.
  - addr[15:14]=11 & m128 & page_ram=5: entry address {0, addr[13:0]}.
  - addr[15:14]=11 & m128 & page_ram=7: entry address {1, addr[13:0]}.
  - Anything else, including every address when m128=0 outside 0x4000-0x7FFF: no capture.
- A matching capture pushes {addr15, data8} in the next cycle.

FIFO:
- Circular buffer with read and write pointers of width clog2(FIFO_DEPTH), plus a level counter.
- Full means level=FIFO_DEPTH. A push while full is dropped, the FIFO is left unchanged, and `overflow` is set to 1. `overflow` clears only on reset.
- A simultaneous push and pop leaves the level unchanged, including when full: the pop frees a slot, so the push is accepted.
- Pointers wrap from FIFO_DEPTH-1 to 0.

Slot arbiter. `vslot` is `ce_7mn` registered by one cycle. In each cycle exactly one of:
- V slot (`vslot`=1): ram_addr=vram_addr, ram_we=0. Takes priority over everything else.
- W slot (`vslot`=0 and level>0): ram_addr=head.addr, ram_din=head.data, ram_we=1, pop.
- Idle: ram_addr=vram_addr, ram_we=0, ram_din=0.

Read-data path:
- `vram_dout` is loaded from `ram_dout` in the cycle after a V slot.
- It holds that value until the next such load.

Coherence:
- No forwarding from the FIFO to video reads. A video read may return pre-write data for an address still queued.
- This is accepted: worst-case skew is 4 writes, a few clk_sys cycles.

## Timing

- clk_sys runs at ≥4× the ce_7mn rate. Every pixel period therefore has 1 V slot and ≥3 W/idle slots.
- Read latency, with ce_7mn high in cycle 0:
  - V slot in cycle 1.
  - `ram_dout` valid in cycle 2.
  - `vram_dout` updated at the end of cycle 2.
  - `vram_dout` is stable well before the next ce_7mn.
- Write latency, with the CPU write edge detected in cycle 0:
  - Push in cycle 1.
  - Earliest `ram_we` in cycle 2, or cycle 3 if cycle 2 is a V slot, provided the FIFO was empty.
- `fifo_level` is registered and reflects push/pop one cycle after they occur.
- Reset values:
  - vram_dout=0, ram_we=0, ram_addr=0, ram_din=0, fifo_level=0, overflow=0.
  - wr_q=1, so a write already in progress at reset release is not captured.
  - vslot=0, pointers=0.
- Reset mid-operation: the FIFO contents are discarded and no `ram_we` is asserted during reset cycles.
- A CPU write held low for many cycles produces exactly one capture.
- An M1/refresh cycle (nRFSH=0) never captures.

## Test plan

- Write 0xA5 to 0x4000 with m128=0 -> one `ram_we` pulse with ram_addr=0x0000, ram_din=0xA5; fifo_level goes 1 then 0.
- m128=1, page_ram=7, write 0x3C to 0xC123 -> ram_addr=0x4123. Repeat with page_ram=5 -> 0x0123. Repeat with page_ram=3 -> no `ram_we`.
- Preload VRAM 0x1800=0x47, set vram_addr=0x1800, pulse ce_7mn -> ram_addr=0x1800 with we=0 in cycle 1; vram_dout=0x47 in cycle 3.
- Push writes landing in a V slot cycle -> `ram_we` deferred one cycle; the V-slot read data is unaffected.
- Disable draining by asserting ce_7mn every cycle, then issue 5 screen writes -> fifo_level=4, overflow=1, only the first 4 are written after release in FIFO order.
- Assert reset with fifo_level=3 -> next cycle fifo_level=0, ram_we=0, overflow=0, vram_dout=0; no queued write reaches VRAM.
